// File: rtl/addsub_nibble_seq.sv
// Nibble-serial two's-complement add/subtract: one 4-bit slice reused over NIBBLES cycles.
// Optional signed-overflow output enabled by defining ADDSUB_SEQ_OVF_EN.
module addsub_nibble_seq #(
  parameter int unsigned NIBBLES = 4,
  localparam int unsigned W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         k,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ovf
);

  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e         state_q;
  logic [IdxW-1:0] idx_q;
  logic           carry_q;
  logic           k_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   work_q;

  logic [3:0]     nib_a;
  logic [3:0]     nib_b;
  logic [4:0]     slice_sum;
  logic [W-1:0]   work_d;
  logic           last;

  always_comb begin
    nib_a     = a_q[4*idx_q +: 4];
    nib_b     = b_q[4*idx_q +: 4] ^ {4{k_q}};
    slice_sum = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
    // Result nibbles enter at the top and shift down, so after NIBBLES steps it is aligned.
    work_d    = {slice_sum[3:0], work_q[W-1:4]};
    last      = (idx_q == IdxW'(NIBBLES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s       <= '0;
      cout    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            k_q     <= k;
            carry_q <= k;
            idx_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          carry_q <= slice_sum[4];
          idx_q   <= idx_q + 1'b1;
          work_q  <= work_d;
          if (last) begin
            s       <= work_d;
            cout    <= slice_sum[4];
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ADDSUB_SEQ_OVF_EN
  logic ovf_q;

  // Carry into the MSB is recovered from the MSB sum bit and its two inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state_q == StRun && last) begin
      ovf_q <= (a_q[W-1] ^ b_q[W-1] ^ k_q ^ work_d[W-1]) ^ slice_sum[4];
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_nibble_seq.sv
// Scoreboard bench for addsub_nibble_seq (NIBBLES=4): expectations queued at accept,
// checked against each done pulse together with latency.
module tb_addsub_nibble_seq;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;
  localparam int unsigned LAT = NIB;
`ifdef ADDSUB_SEQ_OVF_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         k = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  exp_t         sb[$];
  int           cyc = 0;
  int           n_vec = 0;
  int           n_err = 0;
  bit           hold_chk = 1'b0;
  logic [W-1:0] s_last = '0;

  addsub_nibble_seq #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .k     (k),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                 input logic xk);
    exp_t m;
    logic [W:0]   sum;
    logic [W-1:0] bb;
    bb     = xk ? ~xb : xb;
    sum    = {1'b0, xa} + {1'b0, bb} + {{W{1'b0}}, xk};
    m.s    = sum[W-1:0];
    m.cout = sum[W];
    m.ovf  = OvfEn && (xa[W-1] == bb[W-1]) && (m.s[W-1] != xa[W-1]);
    m.cyc  = 0;
    return m;
  endfunction

  // Monitor: every done pops one expectation; between pulses s may be required to hold.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("s", 32'(s), 32'(e.s));
        check("cout", 32'(cout), 32'(e.cout));
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("latency", 32'(cyc - e.cyc), 32'(LAT));
        s_last = e.s;
      end
    end else if (hold_chk) begin
      check("s_hold", 32'(s), 32'(s_last));
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Drive at a negedge; returns at the negedge following the accept edge.
  task automatic op_exp(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xk,
                        input exp_t e);
    wait_idle();
    a = xa;
    b = xb;
    k = xk;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xk);
    op_exp(xa, xb, xk, model(xa, xb, xk));
  endtask

  function automatic exp_t mk(input logic [W-1:0] xs, input logic xc, input logic xo);
    exp_t e;
    e.s = xs; e.cout = xc; e.ovf = xo; e.cyc = 0;
    return e;
  endfunction

  task automatic drain();
    int t = 0;
    while (sb.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      check("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors with hand-computed results
    op_exp(16'h1234, 16'h0FFF, 1'b0, mk(16'h2233, 1'b0, 1'b0));
    drain();
    op_exp(16'h0007, 16'h0005, 1'b1, mk(16'h0002, 1'b1, 1'b0));
    drain();
    op_exp(16'h0005, 16'h0007, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
    drain();
    op_exp(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0));
    drain();
    op_exp(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, OvfEn));
    drain();
    op_exp(16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1'b1, OvfEn));
    drain();

    // Start while busy is ignored; start in the done cycle is accepted back-to-back
    op(16'h0100, 16'h0023, 1'b0);
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; k = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int t = 0;
      while (!done && t < 20) begin
        @(negedge clk);
        t++;
      end
      check("first_done_seen", 32'(done), 32'd1);
    end
    op(16'h4321, 16'h1111, 1'b1);
    drain();
    repeat (6) @(negedge clk);

    // Reset at the second RUN edge abandons the operation
    op(16'h0F0F, 16'h0101, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("rrun_busy", 32'(busy), 32'd0);
    check("rrun_done", 32'(done), 32'd0);
    check("rrun_s", 32'(s), 32'd0);
    check("rrun_cout", 32'(cout), 32'd0);
    check("rrun_ovf", 32'(ovf), 32'd0);
    repeat (6) @(negedge clk);
    op_exp(16'h0001, 16'h0001, 1'b0, mk(16'h0002, 1'b0, 1'b0));
    drain();

    // Operand changes during RUN must not leak in; s holds until done
    hold_chk = 1'b1;
    for (int n = 0; n < 4; n++) begin
      logic [W-1:0] xa;
      logic [W-1:0] xb;
      logic         xk;
      xa = W'($urandom);
      xb = W'($urandom);
      xk = 1'($urandom);
      op(xa, xb, xk);
      while (busy) begin
        a = W'($urandom);
        b = W'($urandom);
        k = 1'($urandom);
        @(negedge clk);
      end
      @(negedge clk);
    end
    drain();
    hold_chk = 1'b0;

    // Random back-to-back traffic
    for (int n = 0; n < 12; n++) begin
      op(W'($urandom), W'($urandom), 1'($urandom));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
